// File: rtl/fcl1_pkg.sv
// Shared sizing, state encoding and helpers for the FCL1 sequencer.
package fcl1_pkg;

    localparam int NUM_FILT   = 6;
    localparam int NUM_STRD   = 4;
    localparam int NUM_WROWS  = 5;
    localparam int SRAM_ADDRW = 3;
    localparam int PSUM_WIDTH = 22;
    localparam int ACC_WIDTH  = PSUM_WIDTH + $clog2(NUM_FILT * NUM_STRD);
    localparam int CNT_W      = 3;

    localparam logic [CNT_W-1:0]      FILT_LAST = CNT_W'(NUM_FILT - 1);
    localparam logic [SRAM_ADDRW-1:0] ROW_LAST  = SRAM_ADDRW'(NUM_WROWS - 1);
    localparam logic [CNT_W-1:0]      STRD_LAST = CNT_W'(NUM_STRD - 1);
    localparam logic [CNT_W-1:0]      STRD_CNT  = CNT_W'(NUM_STRD);

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WSETTLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [ACC_WIDTH-1:0] sextPsum(input logic [PSUM_WIDTH-1:0] d);
        return {{(ACC_WIDTH - PSUM_WIDTH){d[PSUM_WIDTH-1]}}, d};
    endfunction

endpackage

// File: rtl/fcl1_acc.sv
// Signed accumulator; exposes its next value so the owner can capture
// a sum that includes the addend arriving in the same cycle.
module fcl1_acc
    import fcl1_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_add,
    input  logic [ACC_WIDTH-1:0] i_data,
    output logic [ACC_WIDTH-1:0] o_next
);

    logic [ACC_WIDTH-1:0] r_acc;

    // Clear has priority so a new pass never inherits a stray addend.
    always_comb begin
        o_next = r_acc;
        if (i_clr) begin
            o_next = '0;
        end else if (i_add) begin
            o_next = r_acc + i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_next;
        end
    end

endmodule

// File: rtl/fcl1_seq_ctrl.sv
// FCL1 sequencer: loads each filter's weight rows, issues its strides and
// accumulates the returned partial sums into one signed result per pass.
module fcl1_seq_ctrl
    import fcl1_pkg::*;
(
    input  logic                  fcl1_top_clk,
    input  logic                  fcl1_top_rst,
    input  logic                  fcl1_top_wake_i,
    input  logic                  fcl1_top_restart_i,
    output logic                  sram_rd_en_o,
    output logic [2:0]            sram_sel_o,
    output logic [SRAM_ADDRW-1:0] sram_addr_o,
    output logic                  wgt_ld_o,
    output logic [2:0]            wgt_row_o,
    output logic                  compute_en_o,
    output logic [2:0]            strd_idx_o,
    input  logic                  compute_valid_i,
    input  logic [PSUM_WIDTH-1:0] compute_data_i,
    output logic                  result_valid_o,
    output logic [ACC_WIDTH-1:0]  result_o,
    output logic                  busy_o,
    output logic                  err_o
);

    state_t                r_state;
    logic [CNT_W-1:0]      r_filt;
    logic [SRAM_ADDRW-1:0] r_row;
    logic [CNT_W-1:0]      r_strd;
    logic [CNT_W-1:0]      r_rcvd;
    logic                  r_rdEn;
    logic                  r_wgtLd;
    logic [SRAM_ADDRW-1:0] r_wgtRow;
    logic                  r_computeEn;
    logic                  r_resValid;
    logic [ACC_WIDTH-1:0]  r_result;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_inWindow;
    logic                  w_accept;
    logic                  w_spurious;
    logic                  w_accClr;
    logic                  w_drainDone;
    logic [ACC_WIDTH-1:0]  w_accNext;

    // Results are only legal while strides are outstanding for the current filter.
    assign w_inWindow  = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_accept    = compute_valid_i && w_inWindow && (r_rcvd < STRD_CNT)
                         && !fcl1_top_restart_i;
    assign w_spurious  = compute_valid_i && !w_accept;
    assign w_accClr    = fcl1_top_restart_i || ((r_state == IDLE) && fcl1_top_wake_i);
    assign w_drainDone = (r_rcvd + CNT_W'(w_accept)) == STRD_CNT;

    fcl1_acc u_acc (
        .i_clk  (fcl1_top_clk),
        .i_rst  (fcl1_top_rst),
        .i_clr  (w_accClr),
        .i_add  (w_accept),
        .i_data (sextPsum(compute_data_i)),
        .o_next (w_accNext)
    );

    always_ff @(posedge fcl1_top_clk or posedge fcl1_top_rst) begin
        if (fcl1_top_rst) begin
            r_state     <= IDLE;
            r_filt      <= '0;
            r_row       <= '0;
            r_strd      <= '0;
            r_rcvd      <= '0;
            r_rdEn      <= 1'b0;
            r_wgtLd     <= 1'b0;
            r_wgtRow    <= '0;
            r_computeEn <= 1'b0;
            r_resValid  <= 1'b0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rdEn      <= 1'b0;
            r_computeEn <= 1'b0;
            r_resValid  <= 1'b0;
            r_wgtLd     <= r_rdEn;
            r_wgtRow    <= r_row;
            if (w_accept) begin
                r_rcvd <= r_rcvd + CNT_W'(1);
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end

            if (fcl1_top_restart_i) begin
                r_state <= IDLE;
                r_filt  <= '0;
                r_row   <= '0;
                r_strd  <= '0;
                r_rcvd  <= '0;
                r_wgtLd <= 1'b0;
                r_busy  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (fcl1_top_wake_i) begin
                            r_state <= WLOAD;
                            r_filt  <= '0;
                            r_row   <= '0;
                            r_rcvd  <= '0;
                            r_rdEn  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    WLOAD: begin
                        if (r_row == ROW_LAST) begin
                            r_state <= WSETTLE;
                        end else begin
                            r_row  <= r_row + SRAM_ADDRW'(1);
                            r_rdEn <= 1'b1;
                        end
                    end
                    WSETTLE: begin
                        r_state     <= ISSUE;
                        r_strd      <= '0;
                        r_computeEn <= 1'b1;
                    end
                    ISSUE: begin
                        if (r_strd == STRD_LAST) begin
                            r_state <= DRAIN;
                        end else begin
                            r_strd      <= r_strd + CNT_W'(1);
                            r_computeEn <= 1'b1;
                        end
                    end
                    // The final sum is taken from the accumulator's next value so a
                    // result landing in the exit cycle is still included.
                    DRAIN: begin
                        if (w_drainDone) begin
                            if (r_filt == FILT_LAST) begin
                                r_state    <= DONE;
                                r_resValid <= 1'b1;
                                r_result   <= w_accNext;
                            end else begin
                                r_state <= WLOAD;
                                r_filt  <= r_filt + CNT_W'(1);
                                r_row   <= '0;
                                r_rcvd  <= '0;
                                r_rdEn  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sram_rd_en_o   = r_rdEn;
    assign sram_sel_o     = r_filt;
    assign sram_addr_o    = r_row;
    assign wgt_ld_o       = r_wgtLd;
    assign wgt_row_o      = r_wgtRow;
    assign compute_en_o   = r_computeEn;
    assign strd_idx_o     = r_strd;
    assign result_valid_o = r_resValid;
    assign result_o       = r_result;
    assign busy_o         = r_busy;
    assign err_o          = r_err;

endmodule

// File: tb/tb_fcl1_seq_ctrl.sv
// Directed bench for fcl1_seq_ctrl: a table of full passes with a small
// compute responder, plus hand-written restart, error and reset sequences.
module tb_fcl1_seq_ctrl;

    typedef struct {
        logic [21:0] psum;
        int          lat;
        bit          gap;
        int          nPass;
        logic [26:0] expResult;
        int          expDoneCycle;
    } passVec_t;

    logic        clk;
    logic        rst;
    logic        wake;
    logic        restart;
    logic        computeValid;
    logic [21:0] computeData;
    logic        rdEn;
    logic [2:0]  sel;
    logic [2:0]  addr;
    logic        wgtLd;
    logic [2:0]  wgtRow;
    logic        computeEn;
    logic [2:0]  strdIdx;
    logic        resValid;
    logic [26:0] result;
    logic        busy;
    logic        err;

    int          nApplied    = 0;
    int          nMiscompare = 0;
    logic [26:0] lastRes     = '0;
    passVec_t    vecs[7];

    fcl1_seq_ctrl dut (
        .fcl1_top_clk       (clk),
        .fcl1_top_rst       (rst),
        .fcl1_top_wake_i    (wake),
        .fcl1_top_restart_i (restart),
        .sram_rd_en_o       (rdEn),
        .sram_sel_o         (sel),
        .sram_addr_o        (addr),
        .wgt_ld_o           (wgtLd),
        .wgt_row_o          (wgtRow),
        .compute_en_o       (computeEn),
        .strd_idx_o         (strdIdx),
        .compute_valid_i    (computeValid),
        .compute_data_i     (computeData),
        .result_valid_o     (resValid),
        .result_o           (result),
        .busy_o             (busy),
        .err_o              (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] allOuts();
        return 64'({rdEn, sel, addr, wgtLd, wgtRow, computeEn, strdIdx,
                    resValid, result, busy, err});
    endfunction

    task automatic applyStimulus(input logic w, input logic r, input logic v,
                                 input logic [21:0] d);
        wake         = w;
        restart      = r;
        computeValid = v;
        computeData  = d;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one pass (or two with wake held) and returns results with the
    // vector's latency; called and returned at posedge+1 with the DUT idle.
    task automatic runPass(input passVec_t v, input bit expErr);
        int         pend[$];
        int         cyc      = 0;
        int         rdCnt    = 0;
        int         enCnt    = 0;
        int         resCnt   = 0;
        int         tDone    = -1;
        int         lastDue  = 0;
        int         due;
        int         delay;
        bit         prevRd   = 1'b0;
        bit         prevEn   = 1'b0;
        bit         prevLd   = 1'b0;
        bit         seenNext = 1'b0;
        bit         finished = 1'b0;
        logic [2:0] prevAddr = '0;
        logic [2:0] prevRow  = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        while (!finished && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (v.nPass == 1 && busy) wake = 1'b0;
            if (prevRd) begin
                checkOutput("wgt_ld", 64'(wgtLd), 64'(1));
                checkOutput("wgt_row", 64'(wgtRow), 64'(prevAddr));
            end else begin
                checkOutput("wgt_ld_quiet", 64'(wgtLd), 64'(0));
            end
            if (rdEn) begin
                if (rdCnt == 0) checkOutput("wake_to_rd", 64'(cyc), 64'(1));
                if (tDone >= 0 && !seenNext) begin
                    checkOutput("b2b_restart_gap", 64'(cyc), 64'(tDone + 2));
                    seenNext = 1'b1;
                end
                checkOutput("sram_sel", 64'(sel), 64'((rdCnt / 5) % 6));
                checkOutput("sram_addr", 64'(addr), 64'(rdCnt % 5));
                rdCnt++;
            end
            if (computeEn) begin
                if (!prevEn) checkOutput("issue_after_ld", 64'({prevLd, prevRow}), 64'(4'b1100));
                checkOutput("strd_idx", 64'(strdIdx), 64'(enCnt % 4));
                enCnt++;
                delay = v.gap ? int'($urandom_range(1, 10)) : v.lat;
                due   = cyc + delay;
                if (due <= lastDue) due = lastDue + 1;
                pend.push_back(due);
                lastDue = due;
            end
            if (tDone >= 0 && cyc == tDone + 1) checkOutput("b2b_idle_busy", 64'(busy), 64'(0));
            if (resValid) begin
                checkOutput("result", 64'(result), 64'(v.expResult));
                if (resCnt == 0) begin
                    if (v.expDoneCycle != 0) checkOutput("done_cycle", 64'(cyc), 64'(v.expDoneCycle));
                    tDone = cyc;
                end
                resCnt++;
                if (resCnt == v.nPass) begin
                    finished = 1'b1;
                    wake     = 1'b0;
                end
            end
            if (pend.size() > 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                computeValid = 1'b1;
                computeData  = v.psum;
            end else begin
                computeValid = 1'b0;
            end
            prevRd   = rdEn;
            prevAddr = addr;
            prevEn   = computeEn;
            prevLd   = wgtLd;
            prevRow  = wgtRow;
        end
        checkOutput("pass_finished", 64'(finished), 64'(1));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("rd_count", 64'(rdCnt), 64'(30 * v.nPass));
        checkOutput("en_count", 64'(enCnt), 64'(24 * v.nPass));
        @(posedge clk);
        #1;
        checkOutput("busy_after", 64'(busy), 64'(0));
        checkOutput("err_after", 64'(err), 64'(expErr));
        checkOutput("valid_after", 64'(resValid), 64'(0));
        checkOutput("result_hold", 64'(result), 64'(v.expResult));
        lastRes = v.expResult;
    endtask

    initial begin
        bit hit;
        bit prevEn;

        vecs[0] = '{22'd1,       5, 1'b0, 1, 27'd24,        91};
        vecs[1] = '{22'h3FFFFF,  2, 1'b0, 1, 27'h7FFFFE8,   73};
        vecs[2] = '{22'h1FFFFF,  1, 1'b0, 1, 27'h2FFFFE8,   67};
        vecs[3] = '{22'h200000,  4, 1'b0, 1, 27'h5000000,   85};
        vecs[4] = '{22'd3,       1, 1'b1, 1, 27'h48,         0};
        vecs[5] = '{22'h3FFFFB,  1, 1'b1, 1, 27'h7FFFF88,    0};
        vecs[6] = '{22'd1,       3, 1'b0, 2, 27'd24,        79};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs", allOuts(), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_reset_outs", allOuts(), 64'(0));
        end

        for (int i = 0; i < 7; i++) begin
            $display("[TB] pass vector %0d", i);
            runPass(vecs[i], 1'b0);
        end

        $display("[TB] spurious valid in IDLE");
        applyStimulus(1'b0, 1'b0, 1'b1, 22'h7);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("err_set", 64'(err), 64'(1));
        checkOutput("err_result_kept", 64'(result), 64'(lastRes));
        repeat (4) @(posedge clk);
        #1;
        checkOutput("err_sticky", 64'(err), 64'(1));
        runPass('{22'd1, 3, 1'b0, 1, 27'd24, 79}, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("err_cleared", 64'(err), 64'(0));

        $display("[TB] restart during filter 3 issue");
        hit    = 1'b0;
        prevEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 500 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (busy) wake = 1'b0;
            computeValid = prevEn;
            computeData  = 22'd1;
            prevEn       = computeEn;
            if (computeEn && sel == 3'd3 && strdIdx == 3'd1) begin
                applyStimulus(1'b0, 1'b1, 1'b0, '0);
                hit = 1'b1;
            end
        end
        checkOutput("restart_reached", 64'(hit), 64'(1));
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("restart_busy", 64'(busy), 64'(0));
        checkOutput("restart_no_valid", 64'(resValid), 64'(0));
        checkOutput("restart_err", 64'(err), 64'(0));
        checkOutput("restart_result_kept", 64'(result), 64'(lastRes));
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            checkOutput("restart_quiet", 64'({busy, resValid, rdEn, computeEn}), 64'(0));
        end

        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("restart_beats_wake", 64'({busy, rdEn}), 64'(0));
        runPass('{22'd2, 4, 1'b0, 1, 27'h30, 85}, 1'b0);

        $display("[TB] async reset mid-pass");
        hit    = 1'b0;
        prevEn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (busy) wake = 1'b0;
            computeValid = prevEn;
            computeData  = 22'd5;
            prevEn       = computeEn;
            if (computeEn && strdIdx == 3'd2) hit = 1'b1;
        end
        checkOutput("areset_reached", 64'(hit), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("areset_outs", allOuts(), 64'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("areset_idle", allOuts(), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
